// File: rtl/serial_paralelo.sv
// -----------------------------------------------------------------------------
// serial_paralelo
//
// Serial-to-parallel deserializer for the receive path.  One bit per clk_8f
// cycle is shifted in MSB first.  Byte alignment is found by hunting for the
// COM character.  The link is declared active after SYNC_COUNT consecutive
// aligned COMs.  From then on every received byte is presented on data_out
// for one full byte period (8 clk_8f cycles), with valid_out flagging
// non-COM bytes.
//
// Optional build macro: SP_OUT_REG_EN
//   When defined, data_out, valid_out and active pass through one extra
//   register stage, which delays every output edge by one clk_8f cycle.
//
// Reset: rst is synchronous and active-low, sampled on the rising edge of
// clk_8f.  It clears all state, including the shift register.
// -----------------------------------------------------------------------------
module serial_paralelo #(
    parameter logic [7:0]  COM_CHAR   = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

    // True when a completed byte equals the alignment character.
    function automatic logic is_com(input logic [7:0] byte_val);
        return (byte_val == COM_CHAR);
    endfunction

    logic [7:0] sr_r;
    logic [7:0] nxt_s;
    state_t     state_r;
    state_t     state_s;
    logic [2:0] bit_cnt_r;
    logic [2:0] bit_cnt_s;
    logic [3:0] com_cnt_r;
    logic [3:0] com_cnt_s;
    logic [7:0] data_r;
    logic [7:0] data_s;
    logic       valid_r;
    logic       valid_s;
    logic       active_r;
    logic       active_s;

    // Next-state, byte counter, COM counter and boundary output logic.
    always_comb begin
        nxt_s     = {sr_r[6:0], data_in};
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r + 3'd1;
        com_cnt_s = com_cnt_r;
        data_s    = data_r;
        valid_s   = valid_r;

        case (state_r)
            ST_HUNT: begin
                // Any cycle can be a boundary while hunting; the COM found
                // here counts as the first of the sync sequence.
                data_s  = 8'h00;
                valid_s = 1'b0;
                if (is_com(nxt_s)) begin
                    bit_cnt_s = 3'd0;
                    com_cnt_s = 4'd1;
                    if (SYNC_TARGET == 4'd1) begin
                        state_s = ST_ACTIVE;
                    end else begin
                        state_s = ST_LOCK;
                    end
                end else begin
                    bit_cnt_s = 3'd0;
                    com_cnt_s = 4'd0;
                end
            end

            ST_LOCK: begin
                data_s  = 8'h00;
                valid_s = 1'b0;
                if (bit_cnt_r == 3'd7) begin
                    if (is_com(nxt_s)) begin
                        com_cnt_s = com_cnt_r + 4'd1;
                        if ((com_cnt_r + 4'd1) == SYNC_TARGET) begin
                            state_s = ST_ACTIVE;
                        end else begin
                            state_s = ST_LOCK;
                        end
                    end else begin
                        // A non-COM on a boundary means the alignment was
                        // a false match straddling two bytes.
                        com_cnt_s = 4'd0;
                        state_s   = ST_HUNT;
                    end
                end else begin
                    state_s = ST_LOCK;
                end
            end

            ST_ACTIVE: begin
                // No loss-of-sync exit: only reset leaves ACTIVE.
                if (bit_cnt_r == 3'd7) begin
                    data_s  = nxt_s;
                    valid_s = !is_com(nxt_s);
                end else begin
                    data_s  = data_r;
                    valid_s = valid_r;
                end
            end

            default: begin
                state_s   = ST_HUNT;
                bit_cnt_s = 3'd0;
                com_cnt_s = 4'd0;
                data_s    = 8'h00;
                valid_s   = 1'b0;
            end
        endcase

        active_s = (state_s == ST_ACTIVE);
    end

    // Shift register, FSM state, counters and boundary output registers.
    always_ff @(posedge clk_8f) begin
        if (!rst) begin
            sr_r      <= 8'h00;
            state_r   <= ST_HUNT;
            bit_cnt_r <= 3'd0;
            com_cnt_r <= 4'd0;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            sr_r      <= nxt_s;
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            com_cnt_r <= com_cnt_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            active_r  <= active_s;
        end
    end

`ifdef SP_OUT_REG_EN
    logic [7:0] data_q_r;
    logic       valid_q_r;
    logic       active_q_r;

    // Extra output stage, adding one clk_8f cycle to every output edge.
    always_ff @(posedge clk_8f) begin
        if (!rst) begin
            data_q_r   <= 8'h00;
            valid_q_r  <= 1'b0;
            active_q_r <= 1'b0;
        end else begin
            data_q_r   <= data_r;
            valid_q_r  <= valid_r;
            active_q_r <= active_r;
        end
    end

    assign data_out  = data_q_r;
    assign valid_out = valid_q_r;
    assign active    = active_q_r;
`else
    assign data_out  = data_r;
    assign valid_out = valid_r;
    assign active    = active_r;
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo
//
// Directed bench for serial_paralelo.  A bit-stream model (sliding 8-bit
// window plus a boundary anchor and modulo-8 arithmetic) predicts the
// outputs every cycle, and literal expectations taken mid-byte pin the model.
// Honours SP_OUT_REG_EN by delaying the predicted outputs one cycle.
// -----------------------------------------------------------------------------
module tb_serial_paralelo;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         SYNC = 4;

    logic       clk_8f = 1'b0;
    logic       rst;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_paralelo #(
        .COM_CHAR   (COM),
        .SYNC_COUNT (SYNC)
    ) dut (
        .clk_8f    (clk_8f),
        .rst       (rst),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    // 8x bit clock.
    always #5 clk_8f = ~clk_8f;

    // ---------------- behavioural model ----------------
    int         t       = 0;
    int         anchor  = 0;
    int         mode    = 0;   // 0 searching, 1 confirming, 2 linked
    int         cnt     = 0;
    logic [7:0] win     = 8'h00;
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_active = 1'b0;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_active;
    logic [7:0] p_data  = 8'h00;
    logic       p_valid = 1'b0;
    logic       p_active = 1'b0;
    bit         started = 1'b0;

    // Predicts outputs from the bit history seen at each rising edge.
    always @(posedge clk_8f) begin
        t = t + 1;
        if (!rst) begin
            win     = 8'h00;
            mode    = 0;
            cnt     = 0;
            m_data  = 8'h00;
            m_valid = 1'b0;
            p_data  = 8'h00;
            p_valid = 1'b0;
            p_active = 1'b0;
        end else begin
            win = {win[6:0], data_in};
            if (mode == 0) begin
                if (win == COM) begin
                    anchor = t;
                    cnt    = 1;
                    mode   = (SYNC == 1) ? 2 : 1;
                end
            end else if (((t - anchor) % 8) == 0) begin
                if (mode == 1) begin
                    if (win == COM) begin
                        cnt = cnt + 1;
                        if (cnt == SYNC) mode = 2;
                    end else begin
                        cnt  = 0;
                        mode = 0;
                    end
                end else begin
                    m_data  = win;
                    m_valid = (win != COM);
                end
            end
        end
        m_active = (mode == 2);
`ifdef SP_OUT_REG_EN
        e_data   = p_data;
        e_valid  = p_valid;
        e_active = p_active;
        if (rst) begin
            p_data   = m_data;
            p_valid  = m_valid;
            p_active = m_active;
        end
`else
        e_data   = m_data;
        e_valid  = m_valid;
        e_active = m_active;
`endif
        started = 1'b1;
    end

    // Compares DUT outputs with the model every cycle, away from the edge.
    always @(negedge clk_8f) begin
        if (started) begin
            n_cmp = n_cmp + 1;
            if (data_out !== e_data || valid_out !== e_valid || active !== e_active) begin
                n_fail = n_fail + 1;
                $display("FAIL model t=%0d: got data=%h valid=%b active=%b, expected data=%h valid=%b active=%b",
                         t, data_out, valid_out, active, e_data, e_valid, e_active);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives bits hi..lo of b, one per cycle; returns on the next negedge.
    task automatic send_range(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            data_in = b[i];
            @(negedge clk_8f);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_range(b, 7, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(negedge clk_8f);
            check("rst_data", data_out, 8'h00);
            check("rst_valid", {7'd0, valid_out}, 8'h00);
            check("rst_active", {7'd0, active}, 8'h00);
        end
        rst = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic v, input logic a);
        check({name, "_data"}, data_out, d);
        check({name, "_valid"}, {7'd0, valid_out}, {7'd0, v});
        check({name, "_active"}, {7'd0, active}, {7'd0, a});
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst     = 1'b0;
        data_in = 1'b0;
        @(negedge clk_8f);

        // Reset held with random serial data.
        do_reset(10);

        // Basic lock and two data bytes.
        repeat (4) send_byte(COM);
        send_range(8'h5A, 7, 4);
        expect_out("sync_com_hidden", 8'h00, 1'b0, 1'b1);
        send_range(8'h5A, 3, 0);
        send_range(8'hC3, 7, 4);
        expect_out("byte_5a", 8'h5A, 1'b1, 1'b1);
        send_range(8'hC3, 3, 0);
        send_range(COM, 7, 4);
        expect_out("byte_c3", 8'hC3, 1'b1, 1'b1);
        send_range(COM, 3, 0);

        // Three-bit misalignment before the sync COMs.
        do_reset(2);
        send_range(8'($urandom_range(0, 255)), 2, 0);
        repeat (4) send_byte(COM);
        send_byte(8'h11);
        send_range(COM, 7, 4);
        expect_out("misalign_11", 8'h11, 1'b1, 1'b1);
        send_range(COM, 3, 0);

        // Broken sync sequence, then re-lock.
        do_reset(2);
        repeat (2) send_byte(COM);
        send_byte(8'h00);
        send_range(COM, 7, 4);
        expect_out("relock_hunt", 8'h00, 1'b0, 1'b0);
        send_range(COM, 3, 0);
        repeat (3) send_byte(COM);
        send_byte(8'h7E);
        send_range(8'hA5, 7, 4);
        expect_out("relock_7e", 8'h7E, 1'b1, 1'b1);

        // Idle COM between data bytes.
        send_range(8'hA5, 3, 0);
        send_range(COM, 7, 4);
        expect_out("idle_a5", 8'hA5, 1'b1, 1'b1);
        send_range(COM, 3, 0);
        send_range(8'h3C, 7, 4);
        expect_out("idle_bc", COM, 1'b0, 1'b1);
        send_range(8'h3C, 3, 0);
        send_range(8'h00, 7, 4);
        expect_out("idle_3c", 8'h3C, 1'b1, 1'b1);

        // Reset mid-byte while active, then full re-sync required.
        send_range(8'h00, 3, 1);
        do_reset(1);
        repeat (3) send_byte(COM);
        send_range(COM, 7, 4);
        expect_out("resync_3com", 8'h00, 1'b0, 1'b0);
        send_range(COM, 3, 0);
        send_range(8'h5A, 7, 4);
        expect_out("resync_4com", 8'h00, 1'b0, 1'b1);
        send_range(8'h5A, 3, 0);
        send_range(COM, 7, 4);
        expect_out("resync_5a", 8'h5A, 1'b1, 1'b1);
        send_range(COM, 3, 0);
        send_byte(COM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
